mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Parametrised shared-memory arbiter for the SoC top.
- Lets NUM_MASTERS request ports share one synchronous memory port. Typical masters are instruction fetch, data load/store and a future DMA/debug port.
- Arbitration is round-robin. The command is latched at grant. A request/ready handshake per master covers memory wait states.
- Sits between the cpu/peripheral masters and the single ram instance. It replaces the direct cpu-to-ram wiring.

Parameters:
- NUM_MASTERS, 2, number of request ports (>=1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8).
- SEL_WIDTH, DATA_WIDTH/8, byte-select width. Derived; do not override.

Ports:
- clock  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- master_request  input  NUM_MASTERS  per-master request; held until that master's ready pulse.
- master_write  input  NUM_MASTERS  per-master 1 = write, 0 = read.
- master_address  input  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at slice i.
- master_select  input  NUM_MASTERS*SEL_WIDTH  packed byte selects.
- master_write_data  input  NUM_MASTERS*DATA_WIDTH  packed write data.
- master_ready  output  NUM_MASTERS  one-cycle completion pulse, one-hot or zero.
- master_read_data  output  DATA_WIDTH  shared read bus; valid only while the served master's ready bit is 1.
- memory_chip_enable  output  1  memory access strobe.
- memory_write_enable  output  1  write qualifier.
- memory_address  output  ADDR_WIDTH  latched address.
- memory_select  output  SEL_WIDTH  latched byte selects.
- memory_write_data  output  DATA_WIDTH  latched write data.
- memory_read_data  input  DATA_WIDTH  read data, valid the cycle after acceptance.
- memory_wait  input  1  memory stall; while 1, the access is not accepted.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE
  - all master_ready = 0
  - master_read_data, memory_address, memory_select, memory_write_data = 0
  - memory_chip_enable = 0, memory_write_enable = 0
  - last_grant = NUM_MASTERS-1, so master 0 wins first
- Reset is released synchronously to clock by the top. Mid-transaction reset aborts the access; no ready is produced.
- FSM states: IDLE, ISSUE, COMPLETE.
- IDLE:
  - If any request is set, choose the winner by round-robin and register its index as grant.
  - Latch that master's write, address, select and write_data. Go to ISSUE.
  - Otherwise stay in IDLE.
- Round-robin order: search last_grant+1, last_grant+2, ... modulo NUM_MASTERS; the first requester found wins. NUM_MASTERS=1 degenerates to a fixed grant.
- ISSUE:
  - memory_chip_enable = 1; memory_write_enable = latched write; address/select/data outputs driven from the latch.
  - If memory_wait = 1, stay in ISSUE with all outputs unchanged.
  - If memory_wait = 0, the access is accepted at this edge; go to COMPLETE.
- COMPLETE:
  - memory_chip_enable = 0.
  - master_ready[grant] = 1 for exactly this cycle.
  - master_read_data = memory_read_data for reads, 0 for writes.
  - last_grant <= grant.
  - Back-to-back: if any master other than grant is requesting, arbitrate among them (grant excluded) and go directly to ISSUE. Otherwise go to IDLE.
  - The served master may drop or renew its request in the ready cycle. A renewed request is seen at the next IDLE/COMPLETE arbitration.
- Latency: request sampled at edge k; memory strobe in cycle k+1; ready in cycle k+2 plus the number of wait cycles.
- Peak throughput: one access per 2 cycles.
- Master inputs that change after grant are ignored until the next grant.
- A request that drops before grant is simply not served; no error is raised.
- A master that drops its request while granted is still served. Masters must not do this.
- Never more than one ready bit set; never more than one outstanding memory access.

Decomposition:
- Shared defines file (existing global macros): CHIP_ENABLE/CHIP_DISABLE, WRITE_ENABLE/WRITE_DISABLE, ZERO_WORD. Add an active-low RESET_ASSERTED constant and the state encodings MEM_ARB_IDLE/ISSUE/COMPLETE.
- One sub-module: rr_picker.
  - Purely combinational.
  - Inputs: request vector, last_grant, exclude mask.
  - Outputs: valid and winner index, width max(1,$clog2(NUM_MASTERS)).
  - Reused later for interrupt arbitration.

Test Plan:
- Single read, N=2: master0 requests read at 0x100, memory returns 0xDEADBEEF, wait=0 -> chip_enable=1, write_enable=0, address=0x100 in cycle 1; master_ready=2'b01 and read_data=0xDEADBEEF in cycle 2.
- Contention, N=3: all three request continuously -> ready pulses in order 0,1,2,0,1,2, one per 2 cycles, never two ready bits set.
- Wait states: memory_wait=1 for 3 cycles during master1's ISSUE -> address/select/data held constant; ready delayed to cycle 5 after request.
- Write: master1 writes 0xA5A5A5A5, select 4'b0011, at 0x20 -> memory_write_enable=1, select=4'b0011, data passed; master_ready=2'b10; master_read_data=0.
- Stability: master0 changes address from 0x40 to 0x80 one cycle after grant -> memory_address stays 0x40 for the whole access.
- Reset mid-access: reset driven 0 during ISSUE -> chip_enable, ready and outputs go to 0 immediately, before the next clock edge. After release with both masters requesting, master0 is served first.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: strobe levels, reset polarity,
// FSM state encodings and the grant-index width helper.
package mem_arbiter_pkg;

    localparam logic CHIP_ENABLE    = 1'b1;
    localparam logic CHIP_DISABLE   = 1'b0;
    localparam logic WRITE_ENABLE   = 1'b1;
    localparam logic WRITE_DISABLE  = 1'b0;
    localparam logic RESET_ASSERTED = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [1:0] MEM_ARB_IDLE     = 2'd0;
    localparam logic [1:0] MEM_ARB_ISSUE    = 2'd1;
    localparam logic [1:0] MEM_ARB_COMPLETE = 2'd2;

    // Width of a master index; a single master still needs one bit.
    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: searches last_grant+1, +2, ... modulo
// NUM_MASTERS and returns the first unmasked requester.
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int INDEX_WIDTH = index_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [INDEX_WIDTH-1:0] last_grant,
    input  logic [NUM_MASTERS-1:0] exclude,
    output logic                   valid,
    output logic [INDEX_WIDTH-1:0] winner
);

    logic [INDEX_WIDTH-1:0] candidate;

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop so
        // no path leaves a value unassigned and no latch is inferred.
        valid     = 1'b0;
        winner    = '0;
        candidate = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            candidate = INDEX_WIDTH'((int'(last_grant) + i) % NUM_MASTERS);
            if (!valid && request[candidate] && !exclude[candidate]) begin
                valid  = 1'b1;
                winner = candidate;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between
// NUM_MASTERS request/ready masters; the winner's command is latched at grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            master_request,
    input  logic [NUM_MASTERS-1:0]            master_write,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_address,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  master_select,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] master_write_data,
    output logic [NUM_MASTERS-1:0]            master_ready,
    output logic [DATA_WIDTH-1:0]             master_read_data,
    output logic                              memory_chip_enable,
    output logic                              memory_write_enable,
    output logic [ADDR_WIDTH-1:0]             memory_address,
    output logic [SEL_WIDTH-1:0]              memory_select,
    output logic [DATA_WIDTH-1:0]             memory_write_data,
    input  logic [DATA_WIDTH-1:0]             memory_read_data,
    input  logic                              memory_wait
);

    localparam int GW = index_width(NUM_MASTERS);

    logic [1:0]             state;
    logic [GW-1:0]          grant;
    logic [GW-1:0]          last_grant;
    logic                   write_q;
    logic [ADDR_WIDTH-1:0]  address_q;
    logic [SEL_WIDTH-1:0]   select_q;
    logic [DATA_WIDTH-1:0]  data_q;

    logic [GW-1:0]          pick_last;
    logic [NUM_MASTERS-1:0] pick_exclude;
    logic                   pick_valid;
    logic [GW-1:0]          pick_winner;
    logic                   take;

    // In COMPLETE the master being served is masked so another requester
    // can be issued back-to-back; last_grant updates on this same edge.
    assign pick_last    = (state == MEM_ARB_COMPLETE) ? grant : last_grant;
    assign pick_exclude = (state == MEM_ARB_COMPLETE) ? (NUM_MASTERS'(1) << grant) : '0;
    assign take         = pick_valid && ((state == MEM_ARB_IDLE) || (state == MEM_ARB_COMPLETE));

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .INDEX_WIDTH (GW)
    ) u_picker (
        .request    (master_request),
        .last_grant (pick_last),
        .exclude    (pick_exclude),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ASSERTED) begin
            state      <= MEM_ARB_IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_MASTERS - 1);
            write_q    <= WRITE_DISABLE;
            address_q  <= '0;
            select_q   <= '0;
            data_q     <= '0;
        end else begin
            if (take) begin
                grant     <= pick_winner;
                write_q   <= master_write[pick_winner];
                address_q <= master_address[int'(pick_winner)*ADDR_WIDTH +: ADDR_WIDTH];
                select_q  <= master_select[int'(pick_winner)*SEL_WIDTH +: SEL_WIDTH];
                data_q    <= master_write_data[int'(pick_winner)*DATA_WIDTH +: DATA_WIDTH];
            end
            case (state)
                MEM_ARB_IDLE: begin
                    if (pick_valid) state <= MEM_ARB_ISSUE;
                end
                MEM_ARB_ISSUE: begin
                    if (!memory_wait) state <= MEM_ARB_COMPLETE;
                end
                MEM_ARB_COMPLETE: begin
                    last_grant <= grant;
                    state      <= pick_valid ? MEM_ARB_ISSUE : MEM_ARB_IDLE;
                end
                default: state <= MEM_ARB_IDLE;
            endcase
        end
    end

    // Strobes and the ready pulse decode straight from state, so an
    // asynchronous reset clears them without waiting for a clock edge.
    assign memory_chip_enable  = (state == MEM_ARB_ISSUE) ? CHIP_ENABLE : CHIP_DISABLE;
    assign memory_write_enable = ((state == MEM_ARB_ISSUE) && write_q) ? WRITE_ENABLE : WRITE_DISABLE;
    assign memory_address      = address_q;
    assign memory_select       = select_q;
    assign memory_write_data   = data_q;
    assign master_ready        = (state == MEM_ARB_COMPLETE) ? (NUM_MASTERS'(1) << grant) : '0;
    assign master_read_data    = ((state == MEM_ARB_COMPLETE) && !write_q) ? memory_read_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a 2-master and a 3-master instance share
// one memory model; expected ready pulses are queued at stimulus time.
module tb_mem_arbiter;

    typedef struct {
        logic [2:0]  ready;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_rd;
    logic        mem_wait;

    logic [1:0]  req2, wr2, rdy2;
    logic [63:0] addr2, wd2;
    logic [7:0]  sel2;
    logic [31:0] rd2, ma2, mwd2;
    logic [3:0]  ms2;
    logic        ce2, we2;

    logic [2:0]  req3, wr3, rdy3;
    logic [95:0] addr3, wd3;
    logic [11:0] sel3;
    logic [31:0] rd3, ma3, mwd3;
    logic [3:0]  ms3;
    logic        ce3, we3;

    exp_t q2[$];
    exp_t q3[$];
    exp_t e2, e3;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.NUM_MASTERS(2)) u2 (
        .clock(clock), .reset(reset),
        .master_request(req2), .master_write(wr2), .master_address(addr2),
        .master_select(sel2), .master_write_data(wd2),
        .master_ready(rdy2), .master_read_data(rd2),
        .memory_chip_enable(ce2), .memory_write_enable(we2),
        .memory_address(ma2), .memory_select(ms2), .memory_write_data(mwd2),
        .memory_read_data(mem_rd), .memory_wait(mem_wait)
    );

    mem_arbiter #(.NUM_MASTERS(3)) u3 (
        .clock(clock), .reset(reset),
        .master_request(req3), .master_write(wr3), .master_address(addr3),
        .master_select(sel3), .master_write_data(wd3),
        .master_ready(rdy3), .master_read_data(rd3),
        .memory_chip_enable(ce3), .memory_write_enable(we3),
        .memory_address(ma3), .memory_select(ms3), .memory_write_data(mwd3),
        .memory_read_data(mem_rd), .memory_wait(1'b0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Scoreboard monitors: every ready pulse must match the head of its queue.
    always @(negedge clock) begin
        if (reset && rdy2 != 2'b00) begin
            check("rdy2_onehot", 64'($onehot(rdy2)), 64'd1);
            if (q2.size() == 0) begin
                check("rdy2_unexpected", 64'(rdy2), 64'd0);
            end else begin
                e2 = q2.pop_front();
                check("rdy2_master", 64'(rdy2), 64'(e2.ready[1:0]));
                check("rdata2", 64'(rd2), 64'(e2.data));
            end
        end
    end

    always @(negedge clock) begin
        if (reset && rdy3 != 3'b000) begin
            check("rdy3_onehot", 64'($onehot(rdy3)), 64'd1);
            if (q3.size() == 0) begin
                check("rdy3_unexpected", 64'(rdy3), 64'd0);
            end else begin
                e3 = q3.pop_front();
                check("rdy3_master", 64'(rdy3), 64'(e3.ready));
                check("rdata3", 64'(rd3), 64'(e3.data));
            end
        end
    end

    initial begin
        reset = 1'b0; mem_rd = '0; mem_wait = 1'b0;
        req2 = '0; wr2 = '0; addr2 = '0; sel2 = '0; wd2 = '0;
        req3 = '0; wr3 = '0; addr3 = '0; sel3 = '0; wd3 = '0;
        repeat (2) @(posedge clock);
        #3;
        check("rst_ce", 64'(ce2), 64'd0);
        check("rst_we", 64'(we2), 64'd0);
        check("rst_ready", 64'(rdy2), 64'd0);
        check("rst_addr", 64'(ma2), 64'd0);
        check("rst_rdata", 64'(rd2), 64'd0);
        check("rst_ready3", 64'(rdy3), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single read by master 0.
        tick();
        req2 = 2'b01; addr2[31:0] = 32'h100; sel2[3:0] = 4'hF; mem_rd = 32'hDEADBEEF;
        q2.push_back('{ready: 3'b001, data: 32'hDEADBEEF});
        tick(); #1;
        check("rd_ce", 64'(ce2), 64'd1);
        check("rd_we", 64'(we2), 64'd0);
        check("rd_addr", 64'(ma2), 64'h100);
        check("rd_ready_early", 64'(rdy2), 64'd0);
        tick(); req2 = 2'b00; #1;
        check("rd_ready", 64'(rdy2), 64'b01);
        check("rd_ce_off", 64'(ce2), 64'd0);
        tick(); #1;
        check("rd_idle", 64'(ce2), 64'd0);

        // Master 1 read with three wait cycles.
        tick();
        req2 = 2'b10; addr2[63:32] = 32'h44; sel2[7:4] = 4'hF; mem_rd = 32'h12345678;
        q2.push_back('{ready: 3'b010, data: 32'h12345678});
        for (int c = 1; c <= 3; c++) begin
            tick(); mem_wait = 1'b1; #1;
            check("wait_ce", 64'(ce2), 64'd1);
            check("wait_addr", 64'(ma2), 64'h44);
            check("wait_sel", 64'(ms2), 64'hF);
            check("wait_ready", 64'(rdy2), 64'd0);
        end
        tick(); mem_wait = 1'b0; #1;
        check("wait_accept_ce", 64'(ce2), 64'd1);
        check("wait_accept_ready", 64'(rdy2), 64'd0);
        tick(); req2 = 2'b00; #1;
        check("wait_ready_c5", 64'(rdy2), 64'b10);
        tick();

        // Master 1 write.
        tick();
        req2 = 2'b10; wr2 = 2'b10; addr2[63:32] = 32'h20; sel2[7:4] = 4'b0011;
        wd2[63:32] = 32'hA5A5A5A5; mem_rd = 32'hFFFFFFFF;
        q2.push_back('{ready: 3'b010, data: 32'h0});
        tick(); #1;
        check("wr_ce", 64'(ce2), 64'd1);
        check("wr_we", 64'(we2), 64'd1);
        check("wr_addr", 64'(ma2), 64'h20);
        check("wr_sel", 64'(ms2), 64'b0011);
        check("wr_data", 64'(mwd2), 64'hA5A5A5A5);
        tick(); req2 = 2'b00; wr2 = 2'b00; #1;
        check("wr_ready", 64'(rdy2), 64'b10);
        check("wr_rdata_zero", 64'(rd2), 64'd0);
        check("wr_we_off", 64'(we2), 64'd0);
        tick();

        // Master 0 changes its address after grant; the latch must hold.
        tick();
        req2 = 2'b01; addr2[31:0] = 32'h40; mem_rd = 32'h0BADF00D;
        q2.push_back('{ready: 3'b001, data: 32'h0BADF00D});
        tick(); addr2[31:0] = 32'h80; mem_wait = 1'b1; #1;
        check("stab_addr_c1", 64'(ma2), 64'h40);
        tick(); mem_wait = 1'b0; #1;
        check("stab_addr_c2", 64'(ma2), 64'h40);
        check("stab_ce_c2", 64'(ce2), 64'd1);
        tick(); req2 = 2'b00; #1;
        check("stab_ready", 64'(rdy2), 64'b01);
        tick();

        // Three-way contention: ready order 0,1,2,0,1,2 every second cycle.
        tick();
        req3 = 3'b111;
        addr3[31:0] = 32'h1000; addr3[63:32] = 32'h1004; addr3[95:64] = 32'h1008;
        mem_rd = 32'hCAFEF00D;
        for (int k = 0; k < 6; k++) q3.push_back('{ready: 3'(1 << (k % 3)), data: 32'hCAFEF00D});
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 12) req3 = 3'b000;
            #1;
            if (c % 2 == 1) begin
                check("cont_ce", 64'(ce3), 64'd1);
                check("cont_addr", 64'(ma3), 64'(32'h1000 + 4 * (((c - 1) / 2) % 3)));
                check("cont_ready_gap", 64'(rdy3), 64'd0);
            end else begin
                check("cont_ready", 64'(rdy3), 64'(1 << (((c - 2) / 2) % 3)));
            end
        end
        tick(); #1;
        check("cont_idle", 64'(ce3), 64'd0);

        // Reset during ISSUE, then both masters request; master 0 goes first.
        tick();
        req2 = 2'b11; addr2[31:0] = 32'h300; addr2[63:32] = 32'h304; mem_rd = 32'h55AA55AA;
        tick(); #1;
        check("pre_rst_ce", 64'(ce2), 64'd1);
        check("pre_rst_addr", 64'(ma2), 64'h304);
        reset = 1'b0; #1;
        check("mid_rst_ce", 64'(ce2), 64'd0);
        check("mid_rst_ready", 64'(rdy2), 64'd0);
        check("mid_rst_addr", 64'(ma2), 64'd0);
        check("mid_rst_sel", 64'(ms2), 64'd0);
        check("mid_rst_wdata", 64'(mwd2), 64'd0);
        check("mid_rst_rdata", 64'(rd2), 64'd0);
        tick(); tick();
        reset = 1'b1;
        q2.push_back('{ready: 3'b001, data: 32'h55AA55AA});
        q2.push_back('{ready: 3'b010, data: 32'h55AA55AA});
        tick(); #1;
        check("post_rst_addr", 64'(ma2), 64'h300);
        check("post_rst_ce", 64'(ce2), 64'd1);
        tick(); req2 = 2'b10; #1;
        check("post_rst_ready0", 64'(rdy2), 64'b01);
        tick(); #1;
        check("b2b_addr", 64'(ma2), 64'h304);
        check("b2b_ce", 64'(ce2), 64'd1);
        tick(); req2 = 2'b00; #1;
        check("b2b_ready1", 64'(rdy2), 64'b10);

        repeat (3) tick();
        check("q2_drained", 64'(q2.size()), 64'd0);
        check("q3_drained", 64'(q3.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
